// File: rtl/product_accumulator.sv
// Product accumulator: sums LEN unsigned products into one AW-bit vector result.
// Latency: result (out_valid) is registered, one cycle after the accept that completes the vector.
// Backpressure: in_ready drops while a result waits in DONE; in_ready returns the cycle after out_ready handshake.
// Optional feature: define PRODUCT_ACCUMULATOR_SAT_EN to saturate on overflow instead of wrapping.
module product_accumulator #(
  parameter int PW  = 9,
  parameter int AW  = 16,
  parameter int LEN = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [PW-1:0]                prod,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [AW-1:0]                acc_out,
  output logic                         ovf,
  output logic [$clog2(LEN+1)-1:0]     cnt
);

  localparam int CW = $clog2(LEN + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [AW-1:0]   r_acc;
  logic            r_ovf;
  logic [CW-1:0]   r_cnt;
  logic            r_out_valid;
  logic            r_in_ready;

  logic            w_accept;
  logic [AW:0]     w_sum;
  logic            w_carry;
  logic [AW-1:0]   w_acc_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            w_last;
  logic            w_release;

  // r_in_ready always mirrors (state != DONE) outside reset, so it alone gates accepts.
  assign w_accept  = in_valid && r_in_ready;
  // Product zero-extended one bit beyond the accumulator so the carry is visible.
  assign w_sum     = {1'b0, r_acc} + {{(AW + 1 - PW){1'b0}}, prod};
  assign w_carry   = w_sum[AW];
  assign w_cnt_nxt = r_cnt + CW'(1);
  assign w_last    = (w_cnt_nxt == CW'(LEN));
  assign w_release = r_out_valid && out_ready;

`ifdef PRODUCT_ACCUMULATOR_SAT_EN
  // Once the vector has overflowed, it stays pinned at all-ones until the result is taken.
  assign w_acc_nxt = (w_carry || r_ovf) ? {AW{1'b1}} : w_sum[AW-1:0];
`else
  // Modulo 2^AW: simply drop the carry.
  assign w_acc_nxt = w_sum[AW-1:0];
`endif

  // Vector FSM: accumulate LEN accepts, hold the result in DONE until the consumer takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, ACC: begin
          if (w_accept) begin
            r_acc <= w_acc_nxt;
            r_ovf <= r_ovf | w_carry;
            r_cnt <= w_cnt_nxt;
            if (w_last) begin
              // Covers both LEN==1 (straight from IDLE) and the final product in ACC.
              r_state     <= DONE;
              r_out_valid <= 1'b1;
              r_in_ready  <= 1'b0;
            end else begin
              r_state     <= ACC;
              r_in_ready  <= 1'b1;
            end
          end else begin
            // Bubble: hold everything; in_ready also recovers here after reset release.
            r_in_ready <= 1'b1;
          end
        end
        DONE: begin
          // in_valid is ignored here; upstream keeps its data until in_ready returns.
          if (w_release) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_acc       <= '0;
          r_ovf       <= 1'b0;
          r_cnt       <= '0;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign acc_out   = r_acc;
  assign ovf       = r_ovf;
  assign cnt       = r_cnt;

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: default instance, AW=9 overflow instance, LEN=1 instance.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
// Expected vector results are queued when stimulus is driven and popped when a result appears.
module tb_product_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // default instance (PW=9, AW=16, LEN=4)
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_ovf;
  logic [8:0]  a_prod;
  logic [15:0] a_acc;
  logic [2:0]  a_cnt;

  // overflow instance (AW=9)
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_ovf;
  logic [8:0]  b_prod;
  logic [8:0]  b_acc;
  logic [2:0]  b_cnt;

  // single-product instance (LEN=1)
  logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_ovf;
  logic [8:0]  c_prod;
  logic [15:0] c_acc;
  logic [0:0]  c_cnt;

  product_accumulator #(.PW(9), .AW(16), .LEN(4)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .prod(a_prod),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .acc_out(a_acc), .ovf(a_ovf), .cnt(a_cnt)
  );

  product_accumulator #(.PW(9), .AW(9), .LEN(4)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .prod(b_prod),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .acc_out(b_acc), .ovf(b_ovf), .cnt(b_cnt)
  );

  product_accumulator #(.PW(9), .AW(16), .LEN(1)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .prod(c_prod),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .acc_out(c_acc), .ovf(c_ovf), .cnt(c_cnt)
  );

  typedef struct {
    logic [15:0] acc;
    logic        ovf;
    int          cnt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Offer one product to instance a and return after the accepting edge.
  task automatic push_prod(input logic [8:0] p, output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    a_in_valid = 1'b1;
    a_prod     = p;
    while (!a_in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = a_in_ready;
    @(negedge clk);
    a_in_valid = 1'b0;
  endtask

  // Wait (bounded) for a result on instance a, capture it, then handshake it away.
  task automatic drain(output logic [15:0] acc, output logic ov, output int cn, output bit ok);
    int n;
    n = 0;
    a_out_ready = 1'b0;
    while (!a_out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok  = a_out_valid;
    acc = a_acc;
    ov  = a_ovf;
    cn  = a_cnt;
    a_out_ready = 1'b1;
    @(negedge clk);
    a_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_in_valid = 0; a_prod = '0; a_out_ready = 0;
    b_in_valid = 0; b_prod = '0; b_out_ready = 0;
    c_in_valid = 0; c_prod = '0; c_out_ready = 0;
    repeat (2) @(negedge clk);
    n_checks++; if (a_out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b exp=0", a_out_valid); else n_pass++;
    n_checks++; if (a_acc !== 16'd0) $display("FAIL rst_acc got=%0d exp=0", a_acc); else n_pass++;
    n_checks++; if (a_cnt !== 3'd0) $display("FAIL rst_cnt got=%0d exp=0", a_cnt); else n_pass++;
    n_checks++; if (a_ovf !== 1'b0) $display("FAIL rst_ovf got=%b exp=0", a_ovf); else n_pass++;
    n_checks++; if (a_in_ready !== 1'b0) $display("FAIL rst_in_ready got=%b exp=0", a_in_ready); else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++; if (a_in_ready !== 1'b0) $display("FAIL rel_in_ready_early got=%b exp=0", a_in_ready); else n_pass++;
    @(negedge clk);
    n_checks++; if (a_in_ready !== 1'b1) $display("FAIL rel_in_ready got=%b exp=1", a_in_ready); else n_pass++;
    n_checks++; if (b_in_ready !== 1'b1) $display("FAIL rel_b_in_ready got=%b exp=1", b_in_ready); else n_pass++;
    n_checks++; if (c_in_ready !== 1'b1) $display("FAIL rel_c_in_ready got=%b exp=1", c_in_ready); else n_pass++;
  endtask

  task automatic test_basic_sum();
    logic [8:0] v[4];
    bit ok;
    logic [15:0] g_acc; logic g_ovf; int g_cnt;
    exp_t e;
    v[0] = 9'd6; v[1] = 9'd12; v[2] = 9'd20; v[3] = 9'd30;
    sb.push_back('{acc: 16'd68, ovf: 1'b0, cnt: 4});
    for (int i = 0; i < 4; i++) begin
      push_prod(v[i], ok);
      if (!ok) begin n_checks++; $display("FAIL basic_accept_timeout idx=%0d", i); end
    end
    n_checks++; if (a_out_valid !== 1'b1) $display("FAIL basic_latency out_valid=%b exp=1", a_out_valid); else n_pass++;
    n_checks++; if (a_in_ready !== 1'b0) $display("FAIL basic_done_in_ready got=%b exp=0", a_in_ready); else n_pass++;
    drain(g_acc, g_ovf, g_cnt, ok);
    e = sb.pop_front();
    n_checks++; if (!ok) $display("FAIL basic_result_timeout out_valid never rose"); else n_pass++;
    n_checks++; if (g_acc !== e.acc) $display("FAIL basic_acc got=%0d exp=%0d", g_acc, e.acc); else n_pass++;
    n_checks++; if (g_ovf !== e.ovf) $display("FAIL basic_ovf got=%b exp=%b", g_ovf, e.ovf); else n_pass++;
    n_checks++; if (g_cnt !== e.cnt) $display("FAIL basic_cnt got=%0d exp=%0d", g_cnt, e.cnt); else n_pass++;
    n_checks++; if (a_in_ready !== 1'b1) $display("FAIL basic_after_in_ready got=%b exp=1", a_in_ready); else n_pass++;
    n_checks++; if (a_out_valid !== 1'b0) $display("FAIL basic_after_out_valid got=%b exp=0", a_out_valid); else n_pass++;
    n_checks++; if (a_acc !== 16'd0) $display("FAIL basic_after_acc got=%0d exp=0", a_acc); else n_pass++;
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [15:0] g_acc; logic g_ovf; int g_cnt;
    exp_t e;
    sb.push_back('{acc: 16'd10, ovf: 1'b0, cnt: 4});
    for (int i = 1; i <= 4; i++) begin
      push_prod(9'(i), ok);
      if (!ok) begin n_checks++; $display("FAIL bp_accept_timeout idx=%0d", i); end
      if (i < 4) repeat (i) @(negedge clk);
    end
    a_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (a_acc !== 16'd10) $display("FAIL bp_hold_acc cyc=%0d got=%0d exp=10", i, a_acc); else n_pass++;
      n_checks++; if (a_in_ready !== 1'b0) $display("FAIL bp_hold_in_ready cyc=%0d got=%b exp=0", i, a_in_ready); else n_pass++;
      @(negedge clk);
    end
    drain(g_acc, g_ovf, g_cnt, ok);
    e = sb.pop_front();
    n_checks++; if (!ok) $display("FAIL bp_result_timeout out_valid never rose"); else n_pass++;
    n_checks++; if (g_acc !== e.acc) $display("FAIL bp_acc got=%0d exp=%0d", g_acc, e.acc); else n_pass++;
    n_checks++; if (g_cnt !== e.cnt) $display("FAIL bp_cnt got=%0d exp=%0d", g_cnt, e.cnt); else n_pass++;
    n_checks++; if (a_in_ready !== 1'b1) $display("FAIL bp_after_in_ready got=%b exp=1", a_in_ready); else n_pass++;
    n_checks++; if (a_cnt !== 3'd0) $display("FAIL bp_after_cnt got=%0d exp=0", a_cnt); else n_pass++;
  endtask

  task automatic test_zero_prod();
    bit ok;
    logic [15:0] g_acc; logic g_ovf; int g_cnt;
    exp_t e;
    logic [8:0] v[4];
    v[0] = 9'd0; v[1] = 9'd0; v[2] = 9'd7; v[3] = 9'd0;
    sb.push_back('{acc: 16'd7, ovf: 1'b0, cnt: 4});
    for (int i = 0; i < 4; i++) begin
      push_prod(v[i], ok);
      if (!ok) begin n_checks++; $display("FAIL zero_accept_timeout idx=%0d", i); end
      if (i == 0) begin
        n_checks++; if (a_cnt !== 3'd1) $display("FAIL zero_counts got=%0d exp=1", a_cnt); else n_pass++;
      end
    end
    drain(g_acc, g_ovf, g_cnt, ok);
    e = sb.pop_front();
    n_checks++; if (g_acc !== e.acc) $display("FAIL zero_acc got=%0d exp=%0d", g_acc, e.acc); else n_pass++;
    n_checks++; if (g_cnt !== e.cnt) $display("FAIL zero_cnt got=%0d exp=%0d", g_cnt, e.cnt); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [15:0] g_acc; logic g_ovf; int g_cnt;
    exp_t e;
    push_prod(9'd25, ok);
    push_prod(9'd25, ok);
    n_checks++; if (a_acc !== 16'd50) $display("FAIL rmid_partial_acc got=%0d exp=50", a_acc); else n_pass++;
    n_checks++; if (a_cnt !== 3'd2) $display("FAIL rmid_partial_cnt got=%0d exp=2", a_cnt); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (a_acc !== 16'd0) $display("FAIL rmid_async_acc got=%0d exp=0", a_acc); else n_pass++;
    n_checks++; if (a_cnt !== 3'd0) $display("FAIL rmid_async_cnt got=%0d exp=0", a_cnt); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    sb.push_back('{acc: 16'd4, ovf: 1'b0, cnt: 4});
    for (int i = 0; i < 4; i++) push_prod(9'd1, ok);
    drain(g_acc, g_ovf, g_cnt, ok);
    e = sb.pop_front();
    n_checks++; if (g_acc !== e.acc) $display("FAIL rmid_next_acc got=%0d exp=%0d", g_acc, e.acc); else n_pass++;
    // reset while a finished result is waiting must drop it
    for (int i = 0; i < 4; i++) push_prod(9'd9, ok);
    n_checks++; if (a_out_valid !== 1'b1) $display("FAIL rdone_pre out_valid=%b exp=1", a_out_valid); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (a_out_valid !== 1'b0) $display("FAIL rdone_async out_valid=%b exp=0", a_out_valid); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (a_out_valid !== 1'b0) $display("FAIL rdone_after out_valid=%b exp=0", a_out_valid); else n_pass++;
    n_checks++; if (a_in_ready !== 1'b1) $display("FAIL rdone_after in_ready=%b exp=1", a_in_ready); else n_pass++;
  endtask

  task automatic test_done_isolation();
    bit ok;
    logic [15:0] g_acc; logic g_ovf; int g_cnt;
    exp_t e;
    sb.push_back('{acc: 16'd20, ovf: 1'b0, cnt: 4});
    for (int i = 0; i < 4; i++) push_prod(9'd5, ok);
    a_in_valid = 1'b1;
    a_prod     = 9'd99;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (a_acc !== 16'd20) $display("FAIL iso_hold_acc cyc=%0d got=%0d exp=20", i, a_acc); else n_pass++;
      n_checks++; if (a_cnt !== 3'd4) $display("FAIL iso_hold_cnt cyc=%0d got=%0d exp=4", i, a_cnt); else n_pass++;
    end
    e = sb.pop_front();
    n_checks++; if (a_out_valid !== 1'b1) $display("FAIL iso_out_valid got=%b exp=1", a_out_valid); else n_pass++;
    n_checks++; if (a_acc !== e.acc) $display("FAIL iso_result_acc got=%0d exp=%0d", a_acc, e.acc); else n_pass++;
    a_out_ready = 1'b1;
    @(negedge clk);
    a_out_ready = 1'b0;
    n_checks++; if (a_in_ready !== 1'b1) $display("FAIL iso_after_in_ready got=%b exp=1", a_in_ready); else n_pass++;
    n_checks++; if (a_cnt !== 3'd0) $display("FAIL iso_after_cnt got=%0d exp=0", a_cnt); else n_pass++;
    @(negedge clk);
    a_in_valid = 1'b0;
    n_checks++; if (a_cnt !== 3'd1) $display("FAIL iso_first_cnt got=%0d exp=1", a_cnt); else n_pass++;
    n_checks++; if (a_acc !== 16'd99) $display("FAIL iso_first_acc got=%0d exp=99", a_acc); else n_pass++;
    sb.push_back('{acc: 16'd102, ovf: 1'b0, cnt: 4});
    for (int i = 0; i < 3; i++) push_prod(9'd1, ok);
    drain(g_acc, g_ovf, g_cnt, ok);
    e = sb.pop_front();
    n_checks++; if (g_acc !== e.acc) $display("FAIL iso_vec_acc got=%0d exp=%0d", g_acc, e.acc); else n_pass++;
  endtask

  task automatic test_overflow();
    exp_t e;
    int n;
`ifdef PRODUCT_ACCUMULATOR_SAT_EN
    sb.push_back('{acc: 16'd511, ovf: 1'b1, cnt: 4});
`else
    sb.push_back('{acc: 16'd388, ovf: 1'b1, cnt: 4});
`endif
    @(negedge clk);
    b_in_valid = 1'b1;
    b_prod     = 9'd225;
    repeat (2) @(negedge clk);
    n_checks++; if (b_acc !== 9'd450) $display("FAIL ovf_partial_acc got=%0d exp=450", b_acc); else n_pass++;
    n_checks++; if (b_ovf !== 1'b0) $display("FAIL ovf_partial_flag got=%b exp=0", b_ovf); else n_pass++;
    repeat (2) @(negedge clk);
    b_in_valid = 1'b0;
    n = 0;
    while (!b_out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    e = sb.pop_front();
    n_checks++; if (b_out_valid !== 1'b1) $display("FAIL ovf_out_valid got=%b exp=1", b_out_valid); else n_pass++;
    n_checks++; if ({7'd0, b_acc} !== e.acc) $display("FAIL ovf_acc got=%0d exp=%0d", b_acc, e.acc); else n_pass++;
    n_checks++; if (b_ovf !== e.ovf) $display("FAIL ovf_flag got=%b exp=%b", b_ovf, e.ovf); else n_pass++;
    n_checks++; if (b_cnt !== e.cnt) $display("FAIL ovf_cnt got=%0d exp=%0d", b_cnt, e.cnt); else n_pass++;
    b_out_ready = 1'b1;
    @(negedge clk);
    b_out_ready = 1'b0;
    n_checks++; if (b_ovf !== 1'b0) $display("FAIL ovf_cleared got=%b exp=0", b_ovf); else n_pass++;
  endtask

  task automatic test_len1();
    exp_t e;
    sb.push_back('{acc: 16'd144, ovf: 1'b0, cnt: 1});
    @(negedge clk);
    c_in_valid = 1'b1;
    c_prod     = 9'd144;
    @(negedge clk);
    c_in_valid = 1'b0;
    e = sb.pop_front();
    n_checks++; if (c_out_valid !== 1'b1) $display("FAIL len1_out_valid got=%b exp=1", c_out_valid); else n_pass++;
    n_checks++; if (c_acc !== e.acc) $display("FAIL len1_acc got=%0d exp=%0d", c_acc, e.acc); else n_pass++;
    n_checks++; if (c_cnt !== e.cnt) $display("FAIL len1_cnt got=%0d exp=%0d", c_cnt, e.cnt); else n_pass++;
    n_checks++; if (c_in_ready !== 1'b0) $display("FAIL len1_in_ready got=%b exp=0", c_in_ready); else n_pass++;
    c_out_ready = 1'b1;
    @(negedge clk);
    c_out_ready = 1'b0;
    n_checks++; if (c_in_ready !== 1'b1) $display("FAIL len1_after_in_ready got=%b exp=1", c_in_ready); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic_sum();
    test_backpressure();
    test_zero_prod();
    test_reset_mid();
    test_done_isolation();
    test_overflow();
    test_len1();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
